uart_tx: RTL and testbench
==========================

# uart_tx

Transmit side of the UART link. Accepts a `WIDTH`-bit parallel word with a single-cycle valid strobe and drives a standard asynchronous serial frame on `tx_out`: start bit, data LSB first, optional parity bit, one stop bit. `clk` is the TX bit clock, one serial bit per cycle. The block sits between the system's TX FIFO/synchronizer and the pad, and mirrors the receive path's `deserializer`.

## Interface
- `WIDTH`, 8: data word width, the `` `WIDTH `` macro from `uart_config.sv`. There are no module parameters.

- `clk` in 1: TX bit clock; one frame bit per rising edge.
- `reset_n` in 1: asynchronous reset, active-low.
- `p_data_in` in `WIDTH`: parallel word to send; sampled only on acceptance.
- `data_valid_in` in 1: request strobe; accepted only when the FSM is in IDLE.
- `par_en_in` in 1: 1 inserts a parity bit; sampled on acceptance.
- `par_typ_in` in 1: 0 selects even parity, 1 selects odd; sampled on acceptance.
- `tx_out` out 1: serial line, registered; idles high.
- `busy_out` out 1: registered; high for every cycle of a frame (start through stop).

## Operation
- FSM states are IDLE, START, DATA, PARITY and STOP.
- **IDLE:** `tx_out`=1, `busy_out`=0.
  - If `data_valid_in`=1, latch `p_data_in`, `par_en_in` and `par_typ_in`, then go to START.
- **START:** `tx_out`=0 for one cycle, then go to DATA.
- **DATA:** `WIDTH` cycles, bit 0 first.
  - A bit counter runs 0..`WIDTH`-1.
  - On the last bit, go to PARITY if parity is enabled, otherwise go to STOP.
- **PARITY:** one cycle.
  - Even parity: `tx_out` = XOR-reduce(latched data).
  - Odd parity: `tx_out` = ~XOR-reduce(latched data).
- **STOP:** `tx_out`=1 for one cycle, then go to IDLE.
- `data_valid_in` asserted outside IDLE is ignored, not queued. The upstream block must wait for `busy_out`=0.
- Parity is computed from the latched word. Changes on the inputs during a frame have no effect.
- All outputs are registered, so there are no combinational paths from inputs to outputs.

## Timing
- Reset values, applied asynchronously and able to abort a frame at any point:
  - State is IDLE.
  - `tx_out`=1 and `busy_out`=0.
  - Bit counter, data latch and parity config are all 0.
- Latency: with `data_valid_in` sampled high in IDLE at edge N, the start bit appears on `tx_out` and `busy_out` rises after edge N.
- Frame length: 2+`WIDTH` cycles without parity, 3+`WIDTH` cycles with parity.
- `busy_out` falls after the STOP cycle.
- Minimum gap between frames is one IDLE cycle with `tx_out`=1. Back-to-back throughput is therefore one word per 3+`WIDTH` cycles (no parity) or 4+`WIDTH` cycles (parity).
- When reset is released mid-stream, the line stays high until the next accepted request.

## Structure
- **Shared package `uart_pkg`:**
  - `tx_state_t` enum (IDLE, START, DATA, PARITY, STOP).
  - Parity-type constants `PAR_EVEN`=0 and `PAR_ODD`=1.
  - Idle/stop level constant `LINE_IDLE`=1 and start level `LINE_START`=0.
- `` `WIDTH `` stays in `uart_config.sv`.
- **Sub-module `serializer`:** the counterpart of `deserializer`.
  - Ports: `clk`, `reset_n`, `load_in`, `ser_en_in`, `p_data_in`, `ser_bit_out`, `ser_done_out`.
  - It holds the shift register and bit counter.
  - `ser_done_out` is high while the last bit is presented.
- The top level holds the FSM, the parity logic and the output mux/register.

## Test plan
1. **Reset idle:** assert reset, then release it with no requests → `tx_out`=1 and `busy_out`=0 for 20 cycles.
2. **No parity:** send 0xA5 with `par_en_in`=0 → `tx_out` sequence is 0,1,0,1,0,0,1,0,1,1 (10 cycles), `busy_out` is high for exactly 10 cycles, then `tx_out`=1.
3. **Even/odd parity:**
   - Send 0x03 with even parity → parity bit 0, frame is 11 cycles.
   - Send 0x03 with odd parity → parity bit 1.
   - Send 0x07 with even parity → parity bit 1.
4. **Ignore while busy:** pulse `data_valid_in` with 0xFF mid-frame of 0x00 → only the 0x00 frame is sent, with all data bits 0, and no second frame follows.
5. **Back-to-back:** hold `data_valid_in` high with 0x55, then 0xAA, parity off → the second start bit begins exactly one idle cycle after the first stop bit.
6. **Reset mid-frame:** assert `reset_n`=0 during DATA bit 3 → `tx_out`=1 and `busy_out`=0 immediately. After release, a new 0x3C request produces a clean full frame.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : uart_pkg
//  Description : Shared types, line levels and parity helper for the UART.
//  Revision    : 1.0 - initial release
// ============================================================================
`ifndef UART_CONFIG_SV
`include "uart_config.sv"
`endif

package uart_pkg;

    localparam int DATA_W = `WIDTH;
    localparam int CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic PAR_EVEN   = 1'b0;
    localparam logic PAR_ODD    = 1'b1;
    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Parity bit that makes the total number of ones even (or odd).
    function automatic logic parity_bit(input logic [DATA_W-1:0] d, input logic typ);
        logic x;
        x = ^d;
        case (typ)
            PAR_EVEN: parity_bit = x;
            PAR_ODD:  parity_bit = ~x;
            default:  parity_bit = x;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
//  Interface   : uart_tx_if
//  Description : Request/line bundle between the TX FIFO side and uart_tx.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_if import uart_pkg::*;;

    logic [DATA_W-1:0] p_data_in;
    logic              data_valid_in;
    logic              par_en_in;
    logic              par_typ_in;
    logic              tx_out;
    logic              busy_out;

    modport master (
        output p_data_in, data_valid_in, par_en_in, par_typ_in,
        input  tx_out, busy_out
    );

    modport slave (
        input  p_data_in, data_valid_in, par_en_in, par_typ_in,
        output tx_out, busy_out
    );

endinterface
`default_nettype wire

// File: rtl/serializer.sv
`default_nettype none
// ============================================================================
//  Module      : serializer
//  Description : Shift register and bit counter for the TX data phase.
//                ser_bit_out is the bit to be driven on the line at the next
//                edge; bit 0 is sent by the top from its own latch, so the
//                shifter is loaded already advanced by one position.
//  Revision    : 1.0 - initial release
// ============================================================================
module serializer import uart_pkg::*; (
    input  wire logic              clk,
    input  wire logic              reset_n,
    input  wire logic              load_in,
    input  wire logic              ser_en_in,
    input  wire logic [DATA_W-1:0] p_data_in,
    output logic                   ser_bit_out,
    output logic                   ser_done_out
);

    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_cnt;

    // Load the word (pre-shifted) on acceptance, then shift and count once per data bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (load_in) begin
            r_shift <= p_data_in >> 1;
            r_cnt   <= '0;
        end else if (ser_en_in) begin
            r_shift <= r_shift >> 1;
            r_cnt   <= ser_done_out ? '0 : r_cnt + 1'b1;
        end
    end

    assign ser_bit_out  = r_shift[0];
    assign ser_done_out = (r_cnt == CNT_W'(DATA_W - 1));

endmodule
`default_nettype wire

// File: rtl/uart_config.sv
`default_nettype none
// ============================================================================
//  Module      : uart_config (macro file)
//  Description : Build-wide UART configuration macros.
//  Revision    : 1.0 - initial release
// ============================================================================
`ifndef UART_CONFIG_SV
`define UART_CONFIG_SV

// Data word width of the UART link.
`define WIDTH 8

`endif
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : UART transmitter: start bit, LSB-first data, optional
//                parity, one stop bit. One frame bit per clk. tx_out and
//                busy_out come straight from flops loaded with the value for
//                the state being entered.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx import uart_pkg::*; (
    input  wire logic clk,
    input  wire logic reset_n,
    uart_tx_if.slave  bus
);

    tx_state_t         r_state;
    tx_state_t         w_next;
    logic [DATA_W-1:0] r_data;
    logic              r_par_en;
    logic              r_par_typ;
    logic              r_tx;
    logic              r_busy;

    logic              w_load;
    logic              w_ser_en;
    logic              w_tx_d;
    logic              w_busy_d;
    logic              w_ser_bit;
    logic              w_ser_done;
    logic              w_par;

    serializer u_ser (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_in      (w_load),
        .ser_en_in    (w_ser_en),
        .p_data_in    (bus.p_data_in),
        .ser_bit_out  (w_ser_bit),
        .ser_done_out (w_ser_done)
    );

    assign w_par = parity_bit(r_data, r_par_typ);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state plus the line/busy values for the state being entered.
    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_ser_en = 1'b0;
        w_tx_d   = LINE_IDLE;
        w_busy_d = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.data_valid_in) begin
                    w_next   = START;
                    w_load   = 1'b1;
                    w_tx_d   = LINE_START;
                    w_busy_d = 1'b1;
                end
            end
            START: begin
                w_next   = DATA;
                w_tx_d   = r_data[0];
                w_busy_d = 1'b1;
            end
            DATA: begin
                w_ser_en = 1'b1;
                w_busy_d = 1'b1;
                if (w_ser_done) begin
                    if (r_par_en) begin
                        w_next = PARITY;
                        w_tx_d = w_par;
                    end else begin
                        w_next = STOP;
                        w_tx_d = LINE_IDLE;
                    end
                end else begin
                    w_tx_d = w_ser_bit;
                end
            end
            PARITY: begin
                w_next   = STOP;
                w_tx_d   = LINE_IDLE;
                w_busy_d = 1'b1;
            end
            STOP: begin
                // Leaving STOP: line stays high, busy drops for the IDLE gap.
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx   <= LINE_IDLE;
            r_busy <= 1'b0;
        end else begin
            r_tx   <= w_tx_d;
            r_busy <= w_busy_d;
        end
    end

    // Capture the word and parity configuration on acceptance only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data    <= '0;
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
        end else if (w_load) begin
            r_data    <= bus.p_data_in;
            r_par_en  <= bus.par_en_in;
            r_par_typ <= bus.par_typ_in;
        end
    end

    assign bus.tx_out   = r_tx;
    assign bus.busy_out = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx
//  Description : Self-checking bench for uart_tx (table vectors, directed
//                corner sequences, random frames against a frame model).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;
    import uart_pkg::*;

    logic clk = 1'b0;
    logic reset_n;

    uart_tx_if bus ();

    uart_tx dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              pe;
        logic              pt;
        int                exp_len;
        logic              exp_par;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference frame from the framing rules: 0, data LSB first, parity, 1.
    function automatic int model_frame(input logic [DATA_W-1:0] d, input logic pe,
                                       input logic pt, output logic bits [0:15]);
        int n;
        int ones;
        for (int k = 0; k < 16; k++) bits[k] = 1'b1;
        bits[0] = 1'b0;
        for (int i = 0; i < DATA_W; i++) bits[1 + i] = logic'((int'(d) >> i) % 2);
        n = 1 + DATA_W;
        if (pe) begin
            ones = $countones(d);
            bits[n] = pt ? logic'((ones + 1) % 2) : logic'(ones % 2);
            n++;
        end
        bits[n] = 1'b1;
        n++;
        return n;
    endfunction

    // Issue a request and record tx_out for every busy cycle (bounded).
    task automatic capture(input logic [DATA_W-1:0] d, input logic pe, input logic pt,
                           input bit hold, input int glitch_at,
                           output int len, output logic bits [0:15]);
        bus.p_data_in     = d;
        bus.par_en_in     = pe;
        bus.par_typ_in    = pt;
        bus.data_valid_in = 1'b1;
        @(negedge clk);
        if (!hold) bus.data_valid_in = 1'b0;
        len = 0;
        for (int k = 0; k < 16; k++) bits[k] = 1'b1;
        while (bus.busy_out === 1'b1 && len < 16) begin
            bits[len] = bus.tx_out;
            len++;
            if (len == glitch_at) begin
                bus.data_valid_in = 1'b1;
                bus.p_data_in     = '1;
                bus.par_en_in     = 1'b1;
                bus.par_typ_in    = ~pt;
            end else if (len == glitch_at + 1) begin
                bus.data_valid_in = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_frame(input string tag, input logic [DATA_W-1:0] d, input logic pe,
                               input logic pt, input bit hold, input int glitch_at,
                               output int len, output logic par_seen);
        logic got [0:15];
        logic exp [0:15];
        int   elen;
        capture(d, pe, pt, hold, glitch_at, len, got);
        elen = model_frame(d, pe, pt, exp);
        chk($sformatf("%s len", tag), len, elen);
        for (int i = 0; i < elen; i++)
            chk($sformatf("%s bit%0d", tag, i), {31'd0, got[i]}, {31'd0, exp[i]});
        chk($sformatf("%s idle gap", tag), {bus.busy_out, bus.tx_out}, 2'b01);
        par_seen = (len >= 2) ? got[len - 2] : 1'bx;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl [4];
        int   len;
        logic par;
        logic ebits [0:15];
        int   elen;

        tbl[0] = '{data: 8'hA5, pe: 1'b0, pt: 1'b0, exp_len: 10, exp_par: 1'b0};
        tbl[1] = '{data: 8'h03, pe: 1'b1, pt: 1'b0, exp_len: 11, exp_par: 1'b0};
        tbl[2] = '{data: 8'h03, pe: 1'b1, pt: 1'b1, exp_len: 11, exp_par: 1'b1};
        tbl[3] = '{data: 8'h07, pe: 1'b1, pt: 1'b0, exp_len: 11, exp_par: 1'b1};

        reset_n           = 1'b0;
        bus.p_data_in     = '0;
        bus.data_valid_in = 1'b0;
        bus.par_en_in     = 1'b0;
        bus.par_typ_in    = 1'b0;

        // Reset and idle line.
        repeat (3) @(negedge clk);
        chk("reset state", {bus.busy_out, bus.tx_out}, 2'b01);
        reset_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk($sformatf("idle c%0d", c), {bus.busy_out, bus.tx_out}, 2'b01);
        end

        // Table vectors: framing, length and parity.
        for (int v = 0; v < 4; v++) begin
            check_frame($sformatf("tbl%0d", v), tbl[v].data, tbl[v].pe, tbl[v].pt, 1'b0, -1, len, par);
            chk($sformatf("tbl%0d busy len", v), len, tbl[v].exp_len);
            if (tbl[v].pe) chk($sformatf("tbl%0d parity", v), {31'd0, par}, {31'd0, tbl[v].exp_par});
        end

        // Request while busy is ignored and not queued.
        check_frame("ignore", 8'h00, 1'b0, 1'b0, 1'b0, 4, len, par);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("ignore quiet c%0d", c), {bus.busy_out, bus.tx_out}, 2'b01);
        end

        // Back-to-back with valid held high: exactly one idle cycle between frames.
        check_frame("b2b0", 8'h55, 1'b0, 1'b0, 1'b1, -1, len, par);
        check_frame("b2b1", 8'hAA, 1'b0, 1'b0, 1'b0, -1, len, par);

        // Reset during data bit 3 aborts the frame immediately.
        elen = model_frame(8'h3C, 1'b0, 1'b0, ebits);
        bus.p_data_in     = 8'h3C;
        bus.par_en_in     = 1'b0;
        bus.par_typ_in    = 1'b0;
        bus.data_valid_in = 1'b1;
        @(negedge clk);
        bus.data_valid_in = 1'b0;
        chk("rst start bit", {bus.busy_out, bus.tx_out}, 2'b10);
        repeat (4) @(negedge clk);
        chk("rst data bit3", {bus.busy_out, bus.tx_out}, {1'b1, ebits[4]});
        reset_n = 1'b0;
        #1;
        chk("rst async", {bus.busy_out, bus.tx_out}, 2'b01);
        @(negedge clk);
        chk("rst held", {bus.busy_out, bus.tx_out}, 2'b01);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rst release c%0d", c), {bus.busy_out, bus.tx_out}, 2'b01);
        end
        check_frame("after rst", 8'h3C, 1'b0, 1'b0, 1'b0, -1, len, par);
        chk("after rst len", len, elen);

        // Random frames against the model.
        for (int r = 0; r < 24; r++) begin
            logic [DATA_W-1:0] d;
            logic              pe;
            logic              pt;
            bit                hold;
            d    = DATA_W'($urandom);
            pe   = logic'($urandom_range(0, 1));
            pt   = logic'($urandom_range(0, 1));
            hold = (r < 23) && ($urandom_range(0, 3) == 0);
            check_frame($sformatf("rnd%0d", r), d, pe, pt, hold, -1, len, par);
        end
        bus.data_valid_in = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
